// File: rtl/br_wb_arbiter.sv
// Write-port arbiter and pending-register scoreboard for the register bank.
// P0 (pipeline write-back) normally wins the single write port. P1 (a
// multi-cycle unit) takes the port when P0 is idle, or by force after
// MAX_WAIT consecutive blocked cycles. The port is driven from registers,
// one cycle after acceptance. The pending vector marks registers whose P1
// result is still in flight.
module br_wb_arbiter #(
  parameter int N        = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic [4:0]    p0_rd,
  input  logic [N-1:0]  p0_data,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic [4:0]    p1_rd,
  input  logic [N-1:0]  p1_data,
  input  logic          rsv_valid,
  input  logic [4:0]    rsv_rd,
  output logic          we,
  output logic [4:0]    a3,
  output logic [N-1:0]  wd3,
  output logic [31:0]   pending
);

  localparam logic [3:0] WaitMax = 4'(MAX_WAIT);

  logic [3:0]  wait_cnt;
  logic        src_p1;
  logic        force1;
  logic        p0_acc;
  logic        p1_acc;
  logic [31:0] pending_nxt;

  // Arbitration: P0 has priority unless P1 has waited MAX_WAIT cycles.
  always_comb begin
    force1   = (wait_cnt == WaitMax) && p1_valid;
    p0_ready = !force1;
    p1_ready = force1 || !p0_valid;
    p0_acc   = p0_valid && p0_ready;
    p1_acc   = p1_valid && p1_ready;
  end

  // Starvation counter for a blocked P1 request, saturating at MAX_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!p1_valid || p1_acc) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WaitMax) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Registered write port; x0 writes are accepted but never enable the bank,
  // and address/data only move when a real write is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we     <= 1'b0;
      a3     <= '0;
      wd3    <= '0;
      src_p1 <= 1'b0;
    end else begin
      we     <= 1'b0;
      src_p1 <= 1'b0;
      if (p0_acc && p0_rd != 5'd0) begin
        we  <= 1'b1;
        a3  <= p0_rd;
        wd3 <= p0_data;
      end else if (p1_acc && p1_rd != 5'd0) begin
        we     <= 1'b1;
        a3     <= p1_rd;
        wd3    <= p1_data;
        src_p1 <= 1'b1;
      end
    end
  end

  // Next pending vector: a committing P1 write clears its bit, a reservation
  // sets one; applying the set last makes it win on a same-bit collision.
  always_comb begin
    pending_nxt = pending;
    if (we && src_p1) begin
      pending_nxt[a3] = 1'b0;
    end
    if (rsv_valid && rsv_rd != 5'd0) begin
      pending_nxt[rsv_rd] = 1'b1;
    end
  end

  // Pending register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule
